// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multi-cycle RV32I control path.
// Holds the FSM state encoding, the instruction classes the decoder
// reports, the ALU operation codes, the opcode values and the write-back
// source selects. It also provides the funct3/funct7 to ALU operation
// mapping that the decoder uses.
package cpu_pkg;

  // FSM states. The encoding is visible on state_o for debug.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  // Instruction classes produced by the decoder.
  typedef enum logic [2:0] {
    CLS_ALU_R   = 3'd0,
    CLS_ALU_I   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_t;

  // ALU operation codes.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // Supported opcodes (IR[6:0]).
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Register-file write-back source selects.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Maps funct3/funct7_5 to an ALU operation. funct7_5 turns ADD into
  // SUB only for register-register instructions (there is no SUBI), but
  // turns SRL into SRA for both forms.
  function automatic logic [3:0] alu_op_decode(input logic [2:0] funct3,
                                               input logic       funct7_5,
                                               input logic       is_reg);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: purely combinational instruction classifier.
// Ports:
//   opcode_i   - IR[6:0]
//   funct3_i   - IR[14:12]
//   funct7_5_i - IR[30]
//   cls_o      - instruction class
//   alu_op_o   - ALU operation for the execute phase
//   illegal_o  - instruction is not supported
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPC_W = 7
) (
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7_5_i,
  output instr_class_t     cls_o,
  output logic [3:0]       alu_op_o,
  output logic             illegal_o
);

  // Loads, stores and branches are only legal for the single funct3
  // value this core implements; everything else falls through to illegal.
  always_comb begin
    cls_o    = CLS_ILLEGAL;
    alu_op_o = ALU_ADD;
    case (opcode_i)
      OPC_OP: begin
        cls_o    = CLS_ALU_R;
        alu_op_o = alu_op_decode(funct3_i, funct7_5_i, 1'b1);
      end
      OPC_OP_IMM: begin
        cls_o    = CLS_ALU_I;
        alu_op_o = alu_op_decode(funct3_i, funct7_5_i, 1'b0);
      end
      OPC_LOAD: begin
        if (funct3_i == 3'b010) cls_o = CLS_LOAD;
      end
      OPC_STORE: begin
        if (funct3_i == 3'b010) cls_o = CLS_STORE;
      end
      OPC_BRANCH: begin
        if (funct3_i == 3'b000) cls_o = CLS_BRANCH;
        alu_op_o = ALU_SUB;
      end
      OPC_JAL: begin
        cls_o = CLS_JAL;
      end
      default: begin
        cls_o = CLS_ILLEGAL;
      end
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM sequencing a shared RV32I datapath through
// FETCH/DECODE/EXEC/MEM/WB, with a sticky TRAP state for illegal
// instructions and a retired-instruction counter. Drives only enables
// and mux selects.
// Ports:
//   clk, rst                     - clock, synchronous active-low reset
//   opcode, funct3, funct7_5     - instruction register fields
//   alu_zero                     - ALU result is zero (branch compare)
//   imem_ready, dmem_ready       - memory handshake completions
//   imem_req, dmem_req, dmem_we  - memory requests
//   ir_we, pc_we, pc_sel         - IR/PC update controls
//   alu_src_a, alu_src_b, alu_op - ALU operand selects and operation
//   rf_we, wb_sel                - register-file write and source
//   retire, halted, instret      - retirement pulse, trap flag, counter
//   state_o                      - current FSM state for debug
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int OPC_W = 7,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic             halted,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  state_t       state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  instr_class_t cls;
  logic [3:0]   dec_alu_op;
  logic         illegal;

  ctrl_decode #(
    .OPC_W(OPC_W)
  ) u_decode (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_5_i(funct7_5),
    .cls_o     (cls),
    .alu_op_o  (dec_alu_op),
    .illegal_o (illegal)
  );

  // Next state and all outputs from the current state plus the decoded IR.
  // There is no ALU result register, so the ALU operands/operation are
  // kept driven in MEM (address) and WB (result being written back).
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = illegal ? TRAP : EXEC;
      end
      EXEC: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: begin
            alu_op    = dec_alu_op;
            alu_src_b = (cls == CLS_ALU_I);
            state_d   = WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_d   = MEM;
          end
          CLS_BRANCH: begin
            alu_op  = ALU_SUB;
            pc_we   = 1'b1;
            pc_sel  = alu_zero;
            retire  = 1'b1;
            state_d = FETCH;
          end
          CLS_JAL: begin
            state_d = WB;
          end
          default: begin
            state_d = TRAP;
          end
        endcase
      end
      MEM: begin
        alu_op    = ALU_ADD;
        alu_src_b = 1'b1;
        dmem_req  = 1'b1;
        dmem_we   = (cls == CLS_STORE);
        if (dmem_ready) begin
          if (cls == CLS_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
        case (cls)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = 1'b1;
          end
          default: begin
            wb_sel    = WB_ALU;
            alu_op    = dec_alu_op;
            alu_src_b = (cls == CLS_ALU_I);
          end
        endcase
      end
      TRAP: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // The counter simply wraps at its width.
  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  // Only the state and the retire counter are registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state_o = state_q;
  assign instret = instret_q;

endmodule
